fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  IF stage of the pipelined ARM core. Owns the fetch PC, issues in-order requests to instruction memory and
//  buffers returned words in a prefetch FIFO. Delivers {instruction, PC} to the decode stage, which consumes
//  Instr[31:12] in the decoder/condlogic path, over a valid/ready handshake.
//  Taken branches and PC writes (PCSrc) arrive as redirect, which flushes all buffered and in-flight fetches.
// PARAMETERS
//  DEPTH      4      prefetch FIFO entries (power of 2, >=2)
//  MAX_OUT    2      max imem requests in flight (1..DEPTH)
//  RESET_PC   32'h0  first fetch address after reset
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous, active-low (0 = reset)
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  fetch address, word aligned
//  imem_gnt     in   1   request accepted this cycle (req&gnt = issue)
//  imem_rvalid  in   1   response valid; responses in order, latency >=1 after issue
//  imem_rdata   in   32  response word
//  redirect     in   1   PC redirect (branch taken / PC write)
//  redirect_pc  in   32  new fetch address
//  if_valid     out  1   if_instr/if_pc valid to decode
//  if_instr     out  32  instruction at FIFO head
//  if_pc        out  32  address of if_instr
//  id_ready     in   1   decode accepts head (pop = if_valid&id_ready)
// BEHAVIOUR
//  Reset (reset==0 at edge): fetch_pc=resp_pc=RESET_PC; FIFO count=0; outstanding=0; discard=0; state=HOLD.
//    Outputs during/after reset: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
//    Reset mid-operation drops all FIFO entries and in-flight responses (late rvalid after reset is ignored,
//    because outstanding=0).
//  FSM: HOLD -> RUN after one cycle. RUN -> DRAIN on redirect if discards are pending. DRAIN -> RUN when
//    discard==0. A redirect in DRAIN stays in DRAIN and recomputes discard. Issue is allowed in RUN and DRAIN.
//  Issue: imem_req = (state!=HOLD) & !redirect & (count+outstanding-discard < DEPTH) & (outstanding < MAX_OUT).
//    imem_addr=fetch_pc (combinational from register).
//    On req&gnt: fetch_pc+=4 (wraps mod 2^32), outstanding+=1. imem_req may drop without gnt.
//  Response: on rvalid, outstanding-=1.
//    If discard>0: word is dropped, discard-=1.
//    Otherwise: push {rdata, resp_pc} and resp_pc+=4.
//    The space reservation in the issue rule guarantees a push never overflows.
//  Output: if_valid = count!=0; if_instr/if_pc = head entry, updated one cycle after the first push into empty
//    (latency rvalid->if_valid = 1 cycle). Head holds stable while if_valid & !id_ready.
//    Push and pop in the same cycle leave count unchanged; the read/write pointers wrap mod DEPTH.
//  Redirect (highest priority):
//    - count->0 and any pop that cycle is void.
//    - fetch_pc = resp_pc = redirect_pc.
//    - discard_next = outstanding - rvalid (all still-in-flight words are dropped).
//    - A same-cycle rvalid word is dropped.
//    - No issue that cycle. First request to redirect_pc is issued on the next cycle.
//  Simultaneous issue+response: outstanding unchanged.
//  Non-word-aligned redirect_pc: bits[1:0] are forced to 0.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_stall[31:0] (cycles with if_valid&!id_ready),
//    perf_flush[15:0] (redirects accepted), perf_drop[15:0] (responses dropped).
//    All counters are saturating, reset to 0, and have no effect on the datapath.
//  FETCH_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  T1 reset: hold reset=0 3 cycles, then release; gnt=1, latency 1
//     -> imem_req rises 1 cycle after release, addr 0x0,0x4,0x8...; if_pc sequence 0x0,0x4 with matching rdata.
//  T2 backpressure: id_ready=0 long, gnt=1
//     -> exactly DEPTH=4 words buffered, imem_req=0, head held stable.
//     -> id_ready=1 resumes fetching with no loss or duplication.
//  T3 redirect with 2 in flight (latency 3): redirect_pc=0x100
//     -> both old responses dropped, if_valid=0 until word@0x100.
//     -> next if_pc=0x100 then 0x104; perf_drop=2 if enabled.
//  T4 redirect coincident with rvalid and pop -> FIFO empty next cycle, rvalid word dropped, fetch_pc=redirect_pc.
//  T5 gnt withheld 10 cycles -> imem_req held with constant addr, outstanding stays 0, no spurious pushes.
//  T6 wrap: redirect_pc=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000;
//     mid-stream reset -> late rvalid ignored, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order imem requests and buffers responses in a prefetch FIFO.
// Optional build macro FETCH_PERF_EN adds saturating stall/flush/drop counters.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall,
    output logic [15:0] perf_flush,
    output logic [15:0] perf_drop
`endif
);

    // state | meaning
    // HOLD  | first cycle after reset, no requests issued
    // RUN   | normal fetching, responses go to the FIFO
    // DRAIN | fetching while stale in-flight responses are still being dropped
    typedef enum logic [1:0] {HOLD, RUN, DRAIN} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + MAX_OUT + 1);

    state_t          state, state_next;
    logic [31:0]     fetch_pc, resp_pc;
    logic [CW-1:0]   count, outstanding, discard, discard_next;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [31:0]     mem_instr [DEPTH];
    logic [31:0]     mem_pc    [DEPTH];

    logic rvalid_eff, push, pop, issue, drop;

    // A response with nothing outstanding (e.g. arriving after a reset) is ignored.
    assign rvalid_eff = imem_rvalid & (outstanding != '0);
    assign drop       = rvalid_eff & (redirect | (discard != '0));
    assign push       = rvalid_eff & ~redirect & (discard == '0);
    assign pop        = if_valid & id_ready & ~redirect;
    assign issue      = imem_req & imem_gnt;

    always_comb begin
        discard_next = discard;
        if (redirect)
            discard_next = outstanding - CW'(rvalid_eff);
        else if (rvalid_eff && discard != '0)
            discard_next = discard - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= HOLD;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HOLD:    state_next = RUN;
            RUN:     if (redirect && discard_next != '0) state_next = DRAIN;
            DRAIN:   if (!redirect && discard == '0) state_next = RUN;
            default: state_next = HOLD;
        endcase
    end

    // Space is reserved for every word that will be kept, so a push can never overflow.
    always_comb begin
        imem_req  = (state != HOLD) & ~redirect
                    & ((count + outstanding - discard) < CW'(DEPTH))
                    & (outstanding < CW'(MAX_OUT));
        imem_addr = fetch_pc;
        if_valid  = (count != '0);
        if_instr  = if_valid ? mem_instr[rd_ptr] : 32'h0;
        if_pc     = if_valid ? mem_pc[rd_ptr]    : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(rvalid_eff);
            discard     <= discard_next;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~32'h3;
                resp_pc  <= redirect_pc & ~32'h3;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= resp_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall <= '0;
            perf_flush <= '0;
            perf_drop  <= '0;
        end else begin
            if (if_valid && !id_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
            if (redirect && perf_flush != '1)              perf_flush <= perf_flush + 16'd1;
            if (drop && perf_drop != '1)                   perf_drop  <= perf_drop + 16'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule
